// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the RGB LCD timing generator:
// pattern selection, colour-bar palette and common panel presets.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    PAT_EXT  = 2'd0,
    PAT_BARS = 2'd1,
    PAT_GRID = 2'd2,
    PAT_GREY = 2'd3
  } pat_sel_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  typedef struct packed {
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned h_disp;
    int unsigned h_front;
    int unsigned v_sync;
    int unsigned v_back;
    int unsigned v_disp;
    int unsigned v_front;
  } lcd_timing_t;

  localparam lcd_timing_t LCD_4P3_800X480 = '{
    h_sync: 128, h_back: 88, h_disp: 800, h_front: 40,
    v_sync: 2,   v_back: 33, v_disp: 480, v_front: 10
  };

  localparam lcd_timing_t LCD_7P0_1024X600 = '{
    h_sync: 20, h_back: 140, h_disp: 1024, h_front: 160,
    v_sync: 3,  v_back: 20,  v_disp: 600,  v_front: 12
  };

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational built-in test pattern source: colour bars, grid and solid grey
// computed from the display coordinate of the pixel currently on DE.
module lcd_pattern_gen #(
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned PIX_W  = 24,
  parameter int unsigned H_DISP = 800
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [1:0]       sel,
  output logic [PIX_W-1:0] rgb
);
  import lcd_timing_pkg::*;

  localparam int unsigned BW = H_DISP / 8;
  localparam int unsigned CW = PIX_W / 3;
  localparam logic [CW-1:0] MID = {1'b1, {(CW-1){1'b0}}};

  logic [2:0]    bar_idx;
  logic [23:0]   bar_c;
  logic [CW-1:0] r, g, b;
  logic          grid_on;

  // Bar index by threshold compare instead of a divide; x beyond 8*BW stays on bar 7.
  always_comb begin
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x >= CNT_W'(k * BW)) bar_idx = 3'(k);
    end
  end

  assign bar_c   = BAR_RGB[bar_idx];
  assign grid_on = ((x & CNT_W'(31)) == '0) || ((y & CNT_W'(31)) == '0);

  always_comb begin
    r   = '0;
    g   = '0;
    b   = '0;
    rgb = '0;
    case (pat_sel_e'(sel))
      PAT_BARS: begin
        r = {CW{bar_c[23]}};
        g = {CW{bar_c[15]}};
        b = {CW{bar_c[7]}};
        rgb[PIX_W-1 -: 3*CW] = {r, g, b};
      end
      PAT_GRID: rgb = grid_on ? '1 : '0;
      PAT_GREY: rgb[PIX_W-1 -: 3*CW] = {MID, MID, MID};
      default:  rgb = '0;
    endcase
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB LCD timing generator: HS/VS/DE with configurable porches,
// pixel requests issued REQ_LEAD cycles ahead of DE, optional test patterns.
module lcd_timing_gen #(
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned H_DISP   = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned PIX_W    = 24,
  parameter int unsigned REQ_LEAD = 2,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter logic        DE_MODE  = 1'b1
) (
  input  logic             lcd_pclk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       pattern_sel,
  input  logic [PIX_W-1:0] pixel_data,
  output logic             data_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic [CNT_W-1:0] h_disp,
  output logic [CNT_W-1:0] v_disp,
  output logic             frame_start,
  output logic             line_start,
  output logic             lcd_de,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic [PIX_W-1:0] lcd_rgb,
  output logic             lcd_clk,
  output logic             lcd_bl,
  output logic             lcd_rst
);
  import lcd_timing_pkg::*;

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_BEG = CNT_W'(H_SYNC + H_BACK - REQ_LEAD);
  localparam logic [CNT_W-1:0] HA_END = CNT_W'(H_SYNC + H_BACK + H_DISP - REQ_LEAD);
  localparam logic [CNT_W-1:0] VA_BEG = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VA_END = CNT_W'(V_SYNC + V_BACK + V_DISP);

  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic             run, run_nxt, start, win;
  logic             hs_raw, vs_raw;
  pat_sel_e         pat_q;

  logic [REQ_LEAD-1:0]            de_sr, hs_sr, vs_sr;
  logic [REQ_LEAD-1:0][CNT_W-1:0] x_sr, y_sr;
  logic [PIX_W-1:0]               pat_rgb;

  // Idle holds the counters at (0,0); a start (from idle or at wrap) re-enters (0,0).
  always_comb begin
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    run_nxt = run;
    start   = 1'b0;
    if (!run) begin
      if (en) begin
        run_nxt = 1'b1;
        start   = 1'b1;
      end
    end else if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt   = '0;
        run_nxt = en;
        start   = en;
      end else begin
        v_nxt = v_cnt + CNT_W'(1);
      end
    end else begin
      h_nxt = h_cnt + CNT_W'(1);
    end
  end

  assign win = run_nxt && (v_nxt >= VA_BEG) && (v_nxt < VA_END)
                       && (h_nxt >= HA_BEG) && (h_nxt < HA_END);

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      data_req    <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      hs_raw      <= 1'b0;
      vs_raw      <= 1'b0;
      pat_q       <= PAT_EXT;
      de_sr       <= '0;
      hs_sr       <= '0;
      vs_sr       <= '0;
      x_sr        <= '0;
      y_sr        <= '0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      run         <= run_nxt;
      frame_start <= start;
      line_start  <= win && (h_nxt == HA_BEG);
      data_req    <= win;
      pixel_xpos  <= win ? h_nxt - HA_BEG : '0;
      pixel_ypos  <= win ? v_nxt - VA_BEG : '0;
      hs_raw      <= run_nxt && (h_nxt < HS_END);
      vs_raw      <= run_nxt && (v_nxt < VS_END);
      if (frame_start) pat_q <= pat_sel_e'(pattern_sel);
      de_sr[0] <= data_req;
      hs_sr[0] <= hs_raw;
      vs_sr[0] <= vs_raw;
      x_sr[0]  <= pixel_xpos;
      y_sr[0]  <= pixel_ypos;
      for (int unsigned i = 1; i < REQ_LEAD; i++) begin
        de_sr[i] <= de_sr[i-1];
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
        x_sr[i]  <= x_sr[i-1];
        y_sr[i]  <= y_sr[i-1];
      end
    end
  end

  lcd_pattern_gen #(
    .CNT_W  (CNT_W),
    .PIX_W  (PIX_W),
    .H_DISP (H_DISP)
  ) u_pattern (
    .x   (x_sr[REQ_LEAD-1]),
    .y   (y_sr[REQ_LEAD-1]),
    .sel (pat_q),
    .rgb (pat_rgb)
  );

  // Upstream data arrives exactly on the DE cycle, so the final mux is combinational.
  assign lcd_de  = de_sr[REQ_LEAD-1];
  assign lcd_rgb = lcd_de ? ((pat_q == PAT_EXT) ? pixel_data : pat_rgb) : '0;
  assign lcd_hs  = (!DE_MODE && hs_sr[REQ_LEAD-1]) ? HS_POL : ~HS_POL;
  assign lcd_vs  = (!DE_MODE && vs_sr[REQ_LEAD-1]) ? VS_POL : ~VS_POL;

  assign h_disp  = CNT_W'(H_DISP);
  assign v_disp  = CNT_W'(V_DISP);
  assign lcd_clk = lcd_pclk;
  assign lcd_bl  = ~rst;
  assign lcd_rst = ~rst;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a reduced 53x12 raster with REQ_LEAD=4,
// driven sync (HS active-low, VS active-high) and a {A5,y,x} upstream source.
module tb_lcd_timing_gen;

  localparam int unsigned HT = 53;   // 4 + 6 + 40 + 3
  localparam int unsigned VT = 12;   // 2 + 2 + 6 + 2
  localparam int unsigned FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  pattern_sel;
  logic [23:0] pixel_data;
  logic        data_req, frame_start, line_start, lcd_de, lcd_hs, lcd_vs;
  logic [7:0]  pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic [23:0] lcd_rgb;
  logic        lcd_clk, lcd_bl, lcd_rst;

  int n_checks = 0;
  int n_errs   = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] src_pipe [4];

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_SYNC (4), .H_BACK (6), .H_DISP (40), .H_FRONT (3),
    .V_SYNC (2), .V_BACK (2), .V_DISP (6),  .V_FRONT (2),
    .CNT_W (8), .PIX_W (24), .REQ_LEAD (4),
    .HS_POL (1'b0), .VS_POL (1'b1), .DE_MODE (1'b0)
  ) dut (
    .lcd_pclk    (clk),
    .rst         (rst),
    .en          (en),
    .pattern_sel (pattern_sel),
    .pixel_data  (pixel_data),
    .data_req    (data_req),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .h_disp      (h_disp),
    .v_disp      (v_disp),
    .frame_start (frame_start),
    .line_start  (line_start),
    .lcd_de      (lcd_de),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_rgb     (lcd_rgb),
    .lcd_clk     (lcd_clk),
    .lcd_bl      (lcd_bl),
    .lcd_rst     (lcd_rst)
  );

  // Upstream source: answers each request 4 cycles later, junk otherwise.
  always @(posedge clk) begin
    src_pipe[0] <= data_req ? {8'hA5, pixel_ypos, pixel_xpos} : 24'h5A5A5A;
    for (int i = 1; i < 4; i++) src_pipe[i] <= src_pipe[i-1];
  end
  assign pixel_data = src_pipe[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " ctl"}, {data_req, lcd_de, lcd_hs, lcd_vs, line_start, frame_start, lcd_bl, lcd_rst, lcd_clk},
             9'b0_0_1_0_0_0_0_0_0);
    check_eq({tag, " pos"}, {pixel_ypos, pixel_xpos}, 32'h0);
    check_eq({tag, " rgb"}, lcd_rgb, 32'h0);
    check_eq({tag, " disp"}, {h_disp, v_disp}, {8'd40, 8'd6});
  endtask

  // Checks n consecutive cycles starting at frame-relative cycle c0.
  task automatic check_frame(input int c0, input int n, input int pat);
    int h, v, dx, dy, c;
    logic req, de, hs_act, vs_act, ls, fs;
    logic [7:0] ex, ey;
    logic [23:0] src, exp_rgb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c = c0 + i;
      h = c % HT;
      v = c / HT;
      req    = (v >= 4) && (v < 10) && (h >= 6)  && (h < 46);
      de     = (v >= 4) && (v < 10) && (h >= 10) && (h < 50);
      hs_act = (h >= 4) && (h < 8);
      vs_act = (c >= 4) && (c < 110);
      ls     = req && (h == 6);
      fs     = (c == 0);
      ex     = req ? 8'(h - 6) : 8'h0;
      ey     = req ? 8'(v - 4) : 8'h0;
      dx     = h - 10;
      dy     = v - 4;
      case (pat)
        0:       src = {8'hA5, 8'(dy), 8'(dx)};
        1:       src = bars[dx / 5];
        2:       src = (dx == 0 || dx == 32 || dy == 0) ? 24'hFFFFFF : 24'h000000;
        default: src = 24'h808080;
      endcase
      exp_rgb = de ? src : 24'h0;
      check_eq($sformatf("ctl p%0d c%0d", pat, c),
               {data_req, lcd_de, lcd_hs, lcd_vs, line_start, frame_start, lcd_bl, lcd_rst},
               {req, de, ~hs_act, vs_act, ls, fs, 1'b1, 1'b1});
      check_eq($sformatf("pos p%0d c%0d", pat, c), {pixel_ypos, pixel_xpos}, {ey, ex});
      check_eq($sformatf("rgb p%0d c%0d", pat, c), lcd_rgb, exp_rgb);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    pattern_sel = 2'd0;
    repeat (5) begin
      @(negedge clk);
      check_reset_state("reset");
    end
    rst = 1'b0;

    // Frame A external; bars requested mid-frame must wait for the next frame.
    check_frame(0, 301, 0);
    pattern_sel = 2'd1;
    check_frame(301, FR - 301, 0);
    // Frame B bars; grid requested mid-frame.
    check_frame(0, 301, 1);
    pattern_sel = 2'd2;
    check_frame(301, FR - 301, 1);
    // Frame C grid; grey requested mid-frame.
    check_frame(0, 301, 2);
    pattern_sel = 2'd3;
    check_frame(301, FR - 301, 2);
    // Frame D grey; enable dropped mid-frame, frame still completes.
    check_frame(0, 301, 3);
    en = 1'b0;
    check_frame(301, FR - 301, 3);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq($sformatf("idle ctl %0d", i),
               {data_req, lcd_de, lcd_hs, lcd_vs, line_start, frame_start},
               6'b0_0_1_0_0_0);
      check_eq($sformatf("idle rgb %0d", i), lcd_rgb, 32'h0);
    end

    en = 1'b1;
    check_frame(0, 251, 3);

    // Reset in the middle of an active line.
    rst = 1'b1;
    pattern_sel = 2'd0;
    @(negedge clk);
    check_reset_state("rst_mid");
    rst = 1'b0;
    check_frame(0, 300, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised RGB LCD timing generator: the successor to the fixed 800×480 DE-mode driver. It produces HS/VS/DE with configurable porches, sync polarity and sync mode. It issues a pixel request a configurable number of cycles ahead of DE, and can substitute built-in test patterns for upstream pixel data. It sits between the frame-buffer/image-processing read path and the LCD pins, in the `lcd_pclk` domain.

## Interface
- `H_SYNC`, 128: HS width (pclk)
- `H_BACK`, 88: horizontal back porch
- `H_DISP`, 800: active pixels per line
- `H_FRONT`, 40: horizontal front porch
- `V_SYNC`, 2: VS width (lines)
- `V_BACK`, 33: vertical back porch
- `V_DISP`, 480: active lines
- `V_FRONT`, 10: vertical front porch
- `CNT_W`, 11: counter/position width; must hold H_TOTAL-1 and V_TOTAL-1
- `PIX_W`, 24: pixel width (RGB888 when 24)
- `REQ_LEAD`, 2: cycles from `data_req` to matching `lcd_de`; legal 1..H_BACK
- `HS_POL`, 0 / `VS_POL`, 0: sync active level
- `DE_MODE`, 1: 1 = HS/VS held at inactive level; 0 = HS/VS driven
- `lcd_pclk` in 1: pixel clock, sole clock
- `rst` in 1: synchronous, active-high reset
- `en` in 1: run enable, evaluated at frame boundary
- `pattern_sel` in 2: 0 external, 1 colour bars, 2 grid, 3 solid grey
- `pixel_data` in PIX_W: upstream pixel, REQ_LEAD cycles after its request
- `data_req` out 1: pixel request
- `pixel_xpos`, `pixel_ypos` out CNT_W: coordinates of requested pixel
- `h_disp`, `v_disp` out CNT_W: constant H_DISP / V_DISP
- `frame_start`, `line_start` out 1: single-cycle pulses
- `lcd_de`, `lcd_hs`, `lcd_vs` out 1: LCD timing
- `lcd_rgb` out PIX_W: LCD data
- `lcd_clk`, `lcd_bl`, `lcd_rst` out 1: `lcd_clk` = `lcd_pclk`; `lcd_bl` = `lcd_rst` = ~`rst`

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL likewise.
- `h_cnt` wraps H_TOTAL-1→0. `v_cnt` increments on the h wrap and wraps V_TOTAL-1→0.
- Request window: v_cnt ∈ [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP) and h_cnt ∈ [H_SYNC+H_BACK-REQ_LEAD, H_SYNC+H_BACK+H_DISP-REQ_LEAD).
- `data_req` is registered from the window. It is high for exactly H_DISP consecutive cycles per active line, and V_DISP lines per frame.
- `pixel_xpos` counts 0..H_DISP-1 and `pixel_ypos` 0..V_DISP-1, both valid while `data_req`=1. Outside the window both are 0.
- `lcd_de` is `data_req` delayed REQ_LEAD cycles via a shift register.
- `lcd_hs` is active while h_cnt < H_SYNC; `lcd_vs` is active while v_cnt < V_SYNC. Both are registered and aligned to the `lcd_de` timebase. With DE_MODE=1 both stay at their inactive level.
- `lcd_rgb` = `lcd_de` ? source : 0. The source is `pixel_data` for mode 0, or the pattern for x/y delayed REQ_LEAD.
- Colour bars: bar width BW = H_DISP/8 (floor). Bar index = min(x/BW, 7). Order: white, yellow, cyan, green, magenta, red, blue, black.
- Grid: white when x[4:0]==0 or y[4:0]==0, otherwise black.
- Solid grey: 0x808080 (MSB-set mid value for other PIX_W).
- `pattern_sel` is latched only when `frame_start` fires. A change mid-frame takes effect next frame.
- `frame_start`: one cycle at h_cnt==0 && v_cnt==0.
- `line_start`: one cycle coincident with the first `data_req` of each active line.
- `en`:
  - If `en`=0 when the counters wrap to (0,0), the counters hold at 0. No `frame_start` fires, and `data_req`/`lcd_de` stay 0.
  - Deasserting `en` mid-frame lets the frame complete.
  - Reasserting `en` starts a frame at (0,0) on the next cycle, with `frame_start` in that cycle.

## Timing
- Reset (synchronous, wins over all else): h_cnt=v_cnt=0; `data_req`, `lcd_de`, `frame_start`, `line_start`, positions, `lcd_rgb` = 0; `lcd_hs`/`lcd_vs` inactive; `lcd_bl`=`lcd_rst`=0; delay line cleared; latched pattern = 0.
- Cycle after reset release with `en`=1: counters at (0,0) and `frame_start`=1.
- Reset mid-frame restarts at (0,0). Outputs are inactive in the same cycle `rst` is sampled high.
- Pixel latency: the pixel requested at cycle t appears on `lcd_rgb` at t+REQ_LEAD with `lcd_de`=1. Pattern latency is identical.
- Frame period is H_TOTAL×V_TOTAL cycles (554400 at defaults).

## Structure
- Package `lcd_timing_pkg`:
  - pattern-select enum (PAT_EXT, PAT_BARS, PAT_GRID, PAT_GREY)
  - 8-entry RGB888 bar colour constants
  - preset constants for 4.3" 800×480 and 7" 1024×600 panels
- Sub-module `lcd_pattern_gen`: purely combinational pattern from (x, y, sel). Instantiated once.

## Test plan
- Reset: hold `rst` 5 cycles with `en`=1, then release. All outputs at their reset values while `rst` is held; `frame_start` pulses exactly 1 cycle after release.
- Default line: per active line, `data_req` is high for 800 cycles and starts at h_cnt=214. `lcd_de` rises at h_cnt=216, and `pixel_xpos` runs 0..799. Expect 480 such lines per 554400-cycle frame.
- REQ_LEAD=4 with a scoreboard source returning {y,x} on a 4-cycle pipe: `lcd_rgb` matches {ypos, xpos} for every DE cycle, and is 0 otherwise.
- Colour bars: x=0 → 0xFFFFFF, x=100 → 0xFFFF00, x=799 → 0x000000. Set `pattern_sel`=2 at mid-frame: the grid appears only after the next `frame_start`.
- `en` dropped at line 100: the frame completes through line 524 and the counters then hold at 0 with no DE. Reassert `en`: `frame_start` fires next cycle.
- DE_MODE=0, HS_POL=0, VS_POL=1: `lcd_hs` is low for 128 cycles per line; `lcd_vs` is high for 2×1056 cycles per frame.
